dfp_line_adapter: RTL and testbench
===================================

# dfp_line_adapter

Memory-side responder for the cache downstream-facing port (dfp). Accepts a 256-bit cacheline read or write from a cache (icache, dcache or their arbiter), converts it into a four-beat 64-bit burst on the banked memory (bmem) interface, and returns the full line with a single-cycle `dfp_resp`. It sits between the cache arbiter and the memory model/controller and is the only block that drives `dfp_rdata`/`dfp_resp`.

## Interface
- `BEATS`, 4: beats per line; line width is `BEATS*64`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `dfp_addr` in 32: line address; bits [4:0] ignored.
- `dfp_read` in 1: read request, held until `dfp_resp`.
- `dfp_write` in 1: write request, held until `dfp_resp`.
- `dfp_wdata` in 256: write line, stable while `dfp_write` is held.
- `dfp_rdata` out 256: read line, valid only while `dfp_resp`=1.
- `dfp_resp` out 1: one-cycle completion pulse for read or write.
- `bmem_addr` out 32: burst address, `{dfp_addr[31:5],5'b0}`.
- `bmem_read` out 1: read command, one accepted cycle per burst.
- `bmem_write` out 1: write beat valid.
- `bmem_wdata` out 64: write beat, beat 0 = line bits [63:0].
- `bmem_ready` in 1: memory accepts the command/beat this cycle.
- `bmem_raddr` in 32: address tag of the returning read data.
- `bmem_rdata` in 64: read beat.
- `bmem_rvalid` in 1: read beat valid.

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE: `dfp_write` -> latch aligned address, go to WR_DATA; otherwise `dfp_read` -> latch address, go to RD_CMD. If both are high, the write wins, and the read is served after RESP.
- RD_CMD: drive `bmem_read`=1 with `bmem_addr`; when `bmem_ready`=1, go to RD_DATA and clear the 2-bit beat counter.
- RD_DATA: on each `bmem_rvalid`, store `bmem_rdata` into line slice [64*cnt +: 64] and increment the counter. After the beat with cnt=BEATS-1, go to RESP. Gaps between beats are allowed.
- WR_DATA: drive `bmem_write`=1, `bmem_addr`, and `bmem_wdata` = slice cnt of the latched `dfp_wdata`. Increment cnt only when `bmem_ready`=1. After the last accepted beat, go to RESP.
- RESP: `dfp_resp`=1 for exactly one cycle, with `dfp_rdata` = assembled line (reads; don't-care on writes). Then return to IDLE.
- `bmem_rvalid` outside RD_DATA is ignored. `bmem_ready` is ignored in IDLE/RD_DATA/RESP.
- The counter wraps naturally at BEATS; the state change occurs on the wrap.

## Timing
- Reset value of all outputs is 0, including `dfp_rdata` and `bmem_wdata`. State returns to IDLE and the counter clears. Reset mid-burst abandons the transaction with no `dfp_resp`.
- Request seen in IDLE at edge N. The bmem command is visible in cycle N+1.
- Read latency, best case: command at N+1, beats at N+2..N+5, `dfp_resp` at N+6.
- Write latency, best case: beats at N+1..N+4 with `bmem_ready` held, `dfp_resp` at N+5.
- A new request may be accepted in the cycle after `dfp_resp`. The initiator must deassert its request in that cycle.
- All outputs are registered-state decoded; there is no combinational path from bmem inputs to dfp outputs.

## Configuration
- `DFP_LINE_ADAPTER_RADDR_CHECK_EN`
- Defined: each accepted read beat compares `bmem_raddr` with the latched address. A mismatch raises `$error` and the beat is dropped (counter not advanced).
- Undefined: `bmem_raddr` is unused and every `bmem_rvalid` beat in RD_DATA is accepted.

## Structure
- Shared package `rv32i_types`: `dfp_adapter_state_t` enum.
- Constants `DFP_LINE_BITS`=256 and `BMEM_BEAT_BITS`=64 live in the same package.
- Single module, with no sub-module. The line register and beat counter are inline.

## Test plan
- Read of 0x0000_1234: beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> `bmem_addr`=0x0000_1220, `dfp_rdata`={0x44..,0x33..,0x22..,0x11..}, `dfp_resp` exactly 6 cycles after request.
- Write of 0xA0 with line = 256'h0123..EF, `bmem_ready` low on every other cycle -> four beats emitted in order, each held until ready, with a single `dfp_resp`.
- Read with 3 idle cycles between beats 1 and 2 -> line correct and `dfp_resp` delayed by exactly 3 cycles.
- `dfp_read` and `dfp_write` high together -> write burst first, then read burst, with two separate `dfp_resp` pulses.
- `rst`=0 during beat 2 of a read -> all outputs 0 next cycle and no `dfp_resp`. The next read after reset completes correctly.
- With `DFP_LINE_ADAPTER_RADDR_CHECK_EN`: a beat carrying the wrong `bmem_raddr` is ignored and `dfp_resp` waits for four matching beats.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the cache dfp path: line/beat widths and the dfp line adapter FSM encoding.
package rv32i_types;

  localparam int DFP_LINE_BITS  = 256;
  localparam int BMEM_BEAT_BITS = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RESP    = 3'd4
  } dfp_adapter_state_t;

endpackage

// File: rtl/dfp_line_adapter.sv
// Converts one 256-bit dfp line read/write into a four-beat 64-bit bmem burst.
// Optional macro DFP_LINE_ADAPTER_RADDR_CHECK_EN drops read beats whose bmem_raddr does not match.
//
// Handshake: dfp_read/dfp_write are held by the initiator until the one-cycle dfp_resp;
// a bmem command or write beat transfers on any cycle where it is driven and bmem_ready=1;
// a read beat transfers on any cycle in RD_DATA where bmem_rvalid=1.
module dfp_line_adapter
  import rv32i_types::*;
#(
  parameter int BEATS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     dfp_addr,
  input  logic                            dfp_read,
  input  logic                            dfp_write,
  input  logic [BEATS*BMEM_BEAT_BITS-1:0] dfp_wdata,
  output logic [BEATS*BMEM_BEAT_BITS-1:0] dfp_rdata,
  output logic                            dfp_resp,
  output logic [31:0]                     bmem_addr,
  output logic                            bmem_read,
  output logic                            bmem_write,
  output logic [BMEM_BEAT_BITS-1:0]       bmem_wdata,
  input  logic                            bmem_ready,
  input  logic [31:0]                     bmem_raddr,
  input  logic [BMEM_BEAT_BITS-1:0]       bmem_rdata,
  input  logic                            bmem_rvalid,
  output logic [2:0]                      dbg_state
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  dfp_adapter_state_t               state;
  logic [CNT_W-1:0]                 cnt;
  logic [31:0]                      addr_q;
  logic [BEATS*BMEM_BEAT_BITS-1:0]  line_q;
  logic                             beat_ok;
  logic [31:0]                      aligned_addr;
  logic                             unused_addr_lo;

  assign aligned_addr   = {dfp_addr[31:5], 5'b0};
  assign unused_addr_lo = ^dfp_addr[4:0];

`ifdef DFP_LINE_ADAPTER_RADDR_CHECK_EN
  assign beat_ok = (bmem_raddr == addr_q);
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign beat_ok      = 1'b1;
`endif

  // line_q holds the write line while bursting out and collects read beats on the way in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (dfp_write) begin
            addr_q <= aligned_addr;
            line_q <= dfp_wdata;
            state  <= ST_WR_DATA;
          end else if (dfp_read) begin
            addr_q <= aligned_addr;
            state  <= ST_RD_CMD;
          end
        end
        ST_RD_CMD: begin
          if (bmem_ready) begin
            cnt   <= '0;
            state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (bmem_rvalid) begin
            if (beat_ok) begin
              line_q[int'(cnt)*BMEM_BEAT_BITS +: BMEM_BEAT_BITS] <= bmem_rdata;
              cnt <= cnt + 1'b1;
              if (cnt == LAST_BEAT) state <= ST_RESP;
            end
`ifdef DFP_LINE_ADAPTER_RADDR_CHECK_EN
            else begin
              $error("dfp_line_adapter: bmem_raddr %h does not match %h, beat dropped",
                     bmem_raddr, addr_q);
            end
`endif
          end
        end
        ST_WR_DATA: begin
          if (bmem_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state only; nothing from bmem reaches dfp combinationally.
  assign bmem_addr  = addr_q;
  assign bmem_read  = (state == ST_RD_CMD);
  assign bmem_write = (state == ST_WR_DATA);
  assign bmem_wdata = (state == ST_WR_DATA) ?
                      line_q[int'(cnt)*BMEM_BEAT_BITS +: BMEM_BEAT_BITS] : '0;
  assign dfp_resp   = (state == ST_RESP);
  assign dfp_rdata  = (state == ST_RESP) ? line_q : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dfp_line_adapter.sv
// Directed plus randomized bench for dfp_line_adapter with a line/beat reference model.
module tb_dfp_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int gap[4];
  int cmd_wait;
  logic [63:0] exp_q[$];

  dfp_line_adapter #(.BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic clear_gaps;
    for (int i = 0; i < 4; i++) gap[i] = 0;
    cmd_wait = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_resp"}, dfp_resp, 0);
    chk({tag, "_rdata"}, dfp_rdata, 0);
    chk({tag, "_bread"}, bmem_read, 0);
    chk({tag, "_bwrite"}, bmem_write, 0);
    chk({tag, "_baddr"}, bmem_addr, 0);
    chk({tag, "_bwdata"}, bmem_wdata, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Memory side of a read: beat i of the line is line[64*i +: 64]; expected dfp line is the whole line.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line);
    logic [31:0] al;
    int lat;
    int extra;
    al = {addr[31:5], 5'b0};
    dfp_addr = addr;
    dfp_read = 1'b1;
    tick;
    lat = 1;
    extra = 0;
    chk("rd_cmd", bmem_read, 1);
    chk("rd_addr", bmem_addr, al);
    chk("rd_no_write", bmem_write, 0);
    for (int w = 0; w < cmd_wait; w++) begin
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b1;
      bmem_rdata  = {$urandom, $urandom};
      tick;
      lat++;
      extra++;
      chk("rd_cmd_held", bmem_read, 1);
    end
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b1;
    tick;
    lat++;
    bmem_ready = 1'b0;
    chk("rd_cmd_done", bmem_read, 0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        bmem_rvalid = 1'b0;
        bmem_rdata  = {$urandom, $urandom};
        tick;
        lat++;
        extra++;
        chk("rd_wait_resp", dfp_resp, 0);
      end
      bmem_rvalid = 1'b1;
      bmem_rdata  = line[64*i +: 64];
      bmem_raddr  = al;
      tick;
      lat++;
      if (i < 3) chk("rd_no_early_resp", dfp_resp, 0);
    end
    bmem_rvalid = 1'b0;
    chk("rd_resp", dfp_resp, 1);
    chk("rd_line", dfp_rdata, line);
    chk("rd_latency", lat, 6 + extra);
    dfp_read = 1'b0;
    tick;
    chk("rd_pulse_end", dfp_resp, 0);
    chk("rd_rdata_clear", dfp_rdata, 0);
  endtask

  // mode 0: ready always high, 1: ready on every other cycle, 2: random ready
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int mode);
    logic [31:0] al;
    logic rdy;
    int lat;
    int guard;
    al = {addr[31:5], 5'b0};
    dfp_addr  = addr;
    dfp_write = 1'b1;
    dfp_wdata = line;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(line[64*i +: 64]);
    tick;
    lat = 1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (guard % 2 == 1);
      else                rdy = 1'($urandom_range(0, 1));
      chk("wr_valid", bmem_write, 1);
      chk("wr_no_read", bmem_read, 0);
      chk("wr_addr", bmem_addr, al);
      chk("wr_beat", bmem_wdata, exp_q[0]);
      chk("wr_no_resp", dfp_resp, 0);
      bmem_ready = rdy;
      tick;
      lat++;
      guard++;
      if (rdy) void'(exp_q.pop_front());
    end
    bmem_ready = 1'b0;
    chk("wr_drained", exp_q.size(), 0);
    chk("wr_resp", dfp_resp, 1);
    chk("wr_write_off", bmem_write, 0);
    if (mode == 0) chk("wr_latency", lat, 5);
    dfp_write = 1'b0;
    tick;
    chk("wr_pulse_end", dfp_resp, 0);
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    rst = 1'b0;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    clear_gaps();
    tick; tick; tick;
    chk_outputs_zero("reset");
    rst = 1'b1;
    tick;

    // directed read with consecutive beats
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, l);

    // write with ready low on every other cycle
    l = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    do_write(32'h0000_00A0, l, 1);

    // three idle cycles between beats 1 and 2
    gap[2] = 3;
    do_read(32'h8000_0047, rand_line());
    clear_gaps();

    // read and write together: write first, read served after the write response
    dfp_read = 1'b1;
    do_write(32'h0000_2040, rand_line(), 0);
    do_read(32'h0000_3060, rand_line());

    // reset during beat 2 of a read
    a = 32'h0000_4080;
    l = rand_line();
    dfp_addr = a; dfp_read = 1'b1;
    tick;
    bmem_ready = 1'b1;
    tick;
    bmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = l[64*i +: 64]; bmem_raddr = a;
      tick;
    end
    bmem_rdata = l[128 +: 64];
    rst = 1'b0;
    tick;
    chk_outputs_zero("mid_reset");
    rst = 1'b1; bmem_rvalid = 1'b0; dfp_read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("post_reset_no_resp", dfp_resp, 0);
    end
    do_read(32'h0000_50C0, rand_line());

    // randomized mix
    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, rand_line(), int'($urandom_range(0, 2)));
      end else begin
        for (int i = 0; i < 4; i++) gap[i] = int'($urandom_range(0, 2));
        cmd_wait = int'($urandom_range(0, 2));
        do_read(a, rand_line());
        clear_gaps();
      end
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        tick;
        chk("idle_no_resp", dfp_resp, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
